// File: rtl/cordic_angle_feeder.sv
// cordic_angle_feeder: phase accumulator that issues one angle update every
// PERIOD enabled cycles, then folds the phase into [-pi/2, +pi/2] and scales
// it to Q2.6 radians for a CORDIC rotation engine. The fold's reflection is
// reported on cos_neg so the cosine can be negated downstream.
// Optional feature: define CORDIC_FEEDER_DITHER_EN to add an 8-bit LFSR dither
// to the phase seen by the fold stage. The accumulator itself stays undithered.
module cordic_angle_feeder #(
    parameter int PERIOD = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sync_clr,
    input  logic              fcw_load,
    input  logic [15:0]       fcw_in,
    output logic signed [7:0] angle,
    output logic [1:0]        quad,
    output logic              cos_neg,
    output logic              strobe
);

    localparam int            CW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0]      count_q, count_d;
    logic [15:0]        phase_q, phase_d;
    logic [15:0]        fcw_q;
    logic               upd;
    // [0] update issued, [1] fold stage valid, [2] strobe
    logic [2:0]         vld_pipe_q;
    logic [15:0]        s1_phase;
    logic signed [15:0] s1_s;
    logic [15:0]        refl;
    logic signed [15:0] fold_a;
    logic               fold_cn;
    logic signed [15:0] a_q;
    logic               cn1_q;
    logic [1:0]         quad1_q;
    logic signed [24:0] prod;
    logic signed [24:0] scaled;
    logic signed [7:0]  angle_d;
    logic signed [7:0]  angle_q;
    logic [1:0]         quad_q;
    logic               cos_neg_q;

    // Increment register. An accumulate on the load edge still sees the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           fcw_q <= '0;
        else if (fcw_load) fcw_q <= fcw_in;
    end

    // Period counter and accumulator next state. Clear outranks enable.
    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        upd     = 1'b0;
        if (sync_clr) begin
            count_d = '0;
            phase_d = '0;
        end else if (en) begin
            if (count_q == LAST) begin
                count_d = '0;
                phase_d = phase_q + fcw_q;  // modulo wrap, no flag
                upd     = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Counter and accumulator state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            phase_q <= '0;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

    // Valid shift register. It runs every cycle, so an update already in
    // flight still completes after en drops or sync_clr fires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_pipe_q <= '0;
        else     vld_pipe_q <= {vld_pipe_q[1:0], upd};
    end

`ifdef CORDIC_FEEDER_DITHER_EN
    logic [7:0] lfsr_q;

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1. It steps once per update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      lfsr_q <= 8'h01;
        else if (upd) lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    assign s1_phase = phase_q + {8'h00, lfsr_q};
`else
    assign s1_phase = phase_q;
`endif

    // Fold to |a| <= pi/2. The reflection is (+/-32768 - s). Modulo 2^16 both
    // signs reduce to 0x8000 - s, so a single 16-bit subtract covers both cases.
    always_comb begin
        s1_s    = signed'(s1_phase);
        refl    = 16'h8000 - s1_phase;
        fold_a  = s1_s;
        fold_cn = 1'b0;
        if (s1_s > 16'sd16384 || s1_s < -16'sd16384) begin
            fold_a  = signed'(refl);
            fold_cn = 1'b1;
        end
    end

    // Stage 1: folded angle, reflection flag and quadrant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            cn1_q   <= 1'b0;
            quad1_q <= '0;
        end else if (vld_pipe_q[0]) begin
            a_q     <= fold_a;
            cn1_q   <= fold_cn;
            quad1_q <= s1_phase[15:14];
        end
    end

    // Scale: 201/32768 is about pi/2^15 * 64, rounded. The result is clamped to +/-100.
    always_comb begin
        prod   = $signed({{9{a_q[15]}}, a_q}) * 25'sd201 + 25'sd16384;
        scaled = prod >>> 15;
        if (scaled > 25'sd100)       angle_d = 8'sd100;
        else if (scaled < -25'sd100) angle_d = -8'sd100;
        else                         angle_d = scaled[7:0];
    end

    // Stage 2: output registers. They hold between strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            angle_q   <= '0;
            quad_q    <= '0;
            cos_neg_q <= 1'b0;
        end else if (vld_pipe_q[1]) begin
            angle_q   <= angle_d;
            quad_q    <= quad1_q;
            cos_neg_q <= cn1_q;
        end
    end

    assign angle   = angle_q;
    assign quad    = quad_q;
    assign cos_neg = cos_neg_q;
    assign strobe  = vld_pipe_q[2];

endmodule

// File: tb/tb_cordic_angle_feeder.sv
// Directed bench for cordic_angle_feeder in the default build (no dither).
module tb_cordic_angle_feeder;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              sync_clr;
    logic              fcw_load;
    logic [15:0]       fcw_in;
    logic signed [7:0] angle;
    logic [1:0]        quad;
    logic              cos_neg;
    logic              strobe;

    int checks = 0;
    int errors = 0;

    cordic_angle_feeder #(.PERIOD(13)) dut (
        .clk(clk), .rst(rst), .en(en), .sync_clr(sync_clr),
        .fcw_load(fcw_load), .fcw_in(fcw_in),
        .angle(angle), .quad(quad), .cos_neg(cos_neg), .strobe(strobe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] fcw;
        int          ang;
        int          q;
        int          cn;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count the edges until strobe is seen. The wait is bounded so that a
    // missing strobe shows up as a wrong count.
    task automatic wait_strobe(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!strobe && n < 60);
    endtask

    // Clear the phase and load a new increment with the enable off, then enable.
    task automatic start_group(input logic [15:0] f);
        en       = 1'b0;
        sync_clr = 1'b1;
        fcw_load = 1'b1;
        fcw_in   = f;
        tick();
        sync_clr = 1'b0;
        fcw_load = 1'b0;
        repeat (3) tick();
        en = 1'b1;
    endtask

    task automatic chk_out(input string nm, input int a, input int q, input int cn);
        chk({nm, ".angle"},   int'(angle),   a);
        chk({nm, ".quad"},    int'(quad),    q);
        chk({nm, ".cos_neg"}, int'(cos_neg), cn);
    endtask

    initial begin
        int n;
        int seen;
        logic [15:0] cur_fcw;

        tbl[0]  = '{16'h4000,  100, 1, 0};
        tbl[1]  = '{16'h4000,    0, 2, 1};
        tbl[2]  = '{16'h4000, -100, 3, 0};
        tbl[3]  = '{16'h4000,    0, 0, 0};
        tbl[4]  = '{16'h2000,   50, 0, 0};
        tbl[5]  = '{16'h2000,  100, 1, 0};
        tbl[6]  = '{16'h2000,   50, 1, 1};
        tbl[7]  = '{16'h2000,    0, 2, 1};
        tbl[8]  = '{16'h2000,  -50, 2, 1};
        tbl[9]  = '{16'h2000, -100, 3, 0};
        tbl[10] = '{16'h2000,  -50, 3, 0};
        tbl[11] = '{16'h2000,    0, 0, 0};

        rst = 1'b1; en = 1'b0; sync_clr = 1'b0; fcw_load = 1'b0; fcw_in = '0;
        #1;
        chk_out("reset", 0, 0, 0);
        chk("reset.strobe", int'(strobe), 0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Table: update sequences for two increments, including the 0xFFFF->0 wrap.
        cur_fcw = 16'h0000;
        for (int i = 0; i < 12; i++) begin
            bit first;
            first = (i == 0) || (tbl[i].fcw != cur_fcw);
            if (first) begin
                start_group(tbl[i].fcw);
                cur_fcw = tbl[i].fcw;
            end
            wait_strobe(n);
            chk($sformatf("vec%0d.gap", i), n, first ? 15 : 12);
            chk_out($sformatf("vec%0d", i), tbl[i].ang, tbl[i].q, tbl[i].cn);
            tick();
            chk($sformatf("vec%0d.strobe_width", i), int'(strobe), 0);
        end

        // A load on the update edge: that update uses the old increment, the next one the new.
        start_group(16'h2000);
        repeat (12) tick();
        fcw_load = 1'b1;
        fcw_in   = 16'h1000;
        tick();
        fcw_load = 1'b0;
        wait_strobe(n);
        chk("load_on_e0.gap", n, 2);
        chk_out("load_on_e0.old", 50, 0, 0);
        wait_strobe(n);
        chk("load_on_e0.gap2", n, 13);
        chk_out("load_on_e0.new", 75, 0, 0);

        // Enable low for 20 cycles at count 5: the counter freezes and the outputs hold.
        start_group(16'h4000);
        repeat (5) tick();
        en   = 1'b0;
        seen = 0;
        repeat (20) begin
            tick();
            if (strobe) seen++;
        end
        chk("en_hold.strobes", seen, 0);
        chk("en_hold.angle", int'(angle), 75);
        en = 1'b1;
        wait_strobe(n);
        chk("en_hold.gap", n, 10);
        chk_out("en_hold.after", 100, 1, 0);

        // Clear just after the update edge: the in-flight update still strobes, and the next update is phase = fcw.
        repeat (11) tick();
        sync_clr = 1'b1;
        tick();
        sync_clr = 1'b0;
        wait_strobe(n);
        chk("clr.inflight_gap", n, 1);
        chk_out("clr.inflight", 0, 2, 1);
        wait_strobe(n);
        chk("clr.next_gap", n, 14);
        chk_out("clr.next", 100, 1, 0);

        // Reset at count 7: the outputs clear at once, and the first strobe comes 15 cycles after release.
        repeat (5) tick();
        rst = 1'b1;
        #1;
        chk_out("midrst", 0, 0, 0);
        chk("midrst.strobe", int'(strobe), 0);
        tick();
        rst      = 1'b0;
        en       = 1'b1;
        fcw_load = 1'b1;
        fcw_in   = 16'h4000;
        tick();
        fcw_load = 1'b0;
        wait_strobe(n);
        chk("midrst.first_gap", n + 1, 15);
        chk_out("midrst.first", 100, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
